// File: rtl/mem_io_arbiter.sv
// Two-requester memory port arbiter: CPU and UART program loader share one
// synchronous-read memory port through a three-state IDLE/ISSUE/RESP FSM.
module mem_io_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              loader_mode_i,

  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_ack_o,
  output logic [DATA_W-1:0] cpu_rdata_o,

  input  logic              uart_req_i,
  input  logic              uart_we_i,
  input  logic [ADDR_W-1:0] uart_addr_i,
  input  logic [DATA_W-1:0] uart_wdata_i,
  output logic              uart_ack_o,
  output logic [DATA_W-1:0] uart_rdata_o,

  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,

  output logic              busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef enum logic {
    GNT_CPU  = 1'b0,
    GNT_UART = 1'b1
  } grant_e;

  state_e              state_q,   state_d;
  grant_e              grant_q,   grant_d;
  logic                we_q,      we_d;
  logic [ADDR_W-1:0]   addr_q,    addr_d;
  logic [DATA_W-1:0]   wdata_q,   wdata_d;

  logic                cpu_elig;
  logic                uart_elig;
  grant_e              sel;

  // grant_q doubles as last_grant: both are written on the same IDLE->ISSUE edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= GNT_UART;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign cpu_elig  = cpu_req_i & ~loader_mode_i;
  assign uart_elig = uart_req_i;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel     = GNT_CPU;

    if (cpu_elig && uart_elig) begin
      sel = (grant_q == GNT_UART) ? GNT_CPU : GNT_UART;
    end else if (uart_elig) begin
      sel = GNT_UART;
    end else begin
      sel = GNT_CPU;
    end

    case (state_q)
      ST_IDLE: begin
        if (cpu_elig || uart_elig) begin
          state_d = ST_ISSUE;
          grant_d = sel;
          if (sel == GNT_CPU) begin
            we_d    = cpu_we_i;
            addr_d  = cpu_addr_i;
            wdata_d = cpu_wdata_i;
          end else begin
            we_d    = uart_we_i;
            addr_d  = uart_addr_i;
            wdata_d = uart_wdata_i;
          end
        end
      end
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Address/data registers only change on a grant, so they hold between accesses.
  assign mem_en_o    = (state_q == ST_ISSUE);
  assign mem_we_o    = (state_q == ST_ISSUE) & we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  assign cpu_ack_o    = (state_q == ST_RESP) && (grant_q == GNT_CPU);
  assign uart_ack_o   = (state_q == ST_RESP) && (grant_q == GNT_UART);
  assign cpu_rdata_o  = (cpu_ack_o  && !we_q) ? mem_rdata_i : '0;
  assign uart_rdata_o = (uart_ack_o && !we_q) ? mem_rdata_i : '0;

  assign busy_o = (state_q != ST_IDLE);

endmodule
